bus_arbiter_wb8: RTL
====================

BUS_ARBITER_WB8 -- requirements
Module: bus_arbiter_wb8

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255, meaning the number of unacknowledged strobe cycles before a bus error (legal range 1..255).
REQ-002 SHALL have port CLK_I, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST_I, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have ports Mn_CYC_I, Mn_STB_I, Mn_WE_I (input, 1 each), the master n cycle, strobe and write enable, for n=0,1 (M0 is the CPU, M1 a secondary master).
REQ-005 SHALL have ports Mn_ADR_I (input, 32) and Mn_DAT_I (input, 8), the master n address and write data.
REQ-006 SHALL have ports Mn_DAT_O (output, 8) and Mn_ACK_O, Mn_STALL_O, Mn_ERR_O (output, 1 each), the read data, acknowledge, stall and bus error to master n.
REQ-007 SHALL have ports S_CYC_O, S_STB_O, S_WE_O (output, 1 each), S_ADR_O (output, 32) and S_DAT_O (output, 8), which drive the shared slave bus toward the address decoder.
REQ-008 SHALL have ports S_DAT_I (input, 8), S_ACK_I (input, 1) and S_STALL_I (input, 1), the shared slave bus responses.
REQ-009 SHALL have port O_grant, output, 2, a one-hot indication of the current owner (bit n means master n).

Function
REQ-010 SHALL implement a registered FSM with states IDLE, GRANT0 and GRANT1.
REQ-011 In IDLE: only M0_CYC_I high gives next state GRANT0; only M1_CYC_I high gives GRANT1; neither keeps IDLE.
REQ-012 In IDLE with both CYC_I high, the FSM SHALL grant the master not granted last; the last-granted register SHALL reset to M1, so M0 wins the first tie.
REQ-013 A grant SHALL be taken one cycle after CYC_I is seen in IDLE; in IDLE all S_* outputs are 0 and both Mn_STALL_O are 1 whenever their Mn_CYC_I is high.
REQ-014 In GRANTn, the S_* outputs SHALL combinationally follow master n's signals, and Mn_DAT_O, Mn_ACK_O and Mn_STALL_O SHALL follow S_DAT_I, S_ACK_I and S_STALL_I.
REQ-015 In GRANTn, the non-owner SHALL see ACK_O=0, ERR_O=0, STALL_O=1 and DAT_O=0.
REQ-016 The grant SHALL be held for as long as the owner's CYC_I is high, including across multiple strobes with no gap.
REQ-017 On the owner's CYC_I falling, the next state SHALL be IDLE, never a direct switch to the other grant; this makes the bus-idle gap at least one cycle.
REQ-018 An 8-bit timeout counter SHALL:
- clear when it is IDLE, when S_ACK_I=1, or when the owner's STB_I=0;
- otherwise increment each cycle.
REQ-019 When the counter equals TIMEOUT-1 with no ACK:
- the owner SHALL receive ERR_O=1 and ACK_O=1 for exactly one cycle, with DAT_O=8'hFF;
- S_STB_O SHALL be forced to 0 that cycle;
- the counter SHALL then clear.
REQ-020 If S_ACK_I arrives in the same cycle the timeout would fire, the normal ACK SHALL win: ERR_O=0, DAT_O=S_DAT_I.
REQ-021 ACK_O and ERR_O SHALL never be asserted to a master that does not own the bus.
REQ-022 O_grant SHALL be 2'b00 in IDLE, 2'b01 in GRANT0 and 2'b10 in GRANT1.

Reset
REQ-023 While RST_I=1:
- state IDLE, counter 0, last-granted = M1;
- all S_* outputs 0, all Mn_ACK_O and Mn_ERR_O 0, O_grant 2'b00.
REQ-024 RST_I asserted mid-transfer SHALL abort it immediately and asynchronously; no ACK_O or ERR_O is produced for the aborted transfer.
REQ-025 After RST_I falls, arbitration SHALL restart from IDLE on the next clock edge.

Verification
REQ-026 M0 reads 0xFFFFF800 alone, slave acks in 2 cycles with 8'h5A -> O_grant=01, M0_DAT_O=5A with one-cycle ACK, M1 outputs idle.
REQ-027 M0 and M1 raise CYC in the same cycle, three times in succession, each held for one transfer -> grant order M0, M1, M0, with O_grant=00 for at least one cycle between grants.
REQ-028 M1 owns the bus, M0 raises CYC -> M0_STALL_O=1 until M1 drops CYC, then IDLE, then GRANT0.
REQ-029 TIMEOUT=4, slave never acks -> M0 sees ERR_O=1, ACK_O=1 and DAT_O=FF in the 4th strobe cycle, and S_STB_O=0 in that cycle.
REQ-030 TIMEOUT=4, S_ACK_I arrives in the 4th cycle -> normal ACK, ERR_O=0.
REQ-031 RST_I pulsed while GRANT1 with STB high -> outputs zero immediately, O_grant=00, and the next tie grants M0.

Source files
------------

// File: rtl/bus_arbiter_wb8.sv
// Two-master Wishbone (8-bit data) bus arbiter with alternating tie-break and strobe timeout.
// The owner's signals are muxed combinationally onto the shared slave bus.
module bus_arbiter_wb8 #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        M0_CYC_I,
  input  logic        M0_STB_I,
  input  logic        M0_WE_I,
  input  logic [31:0] M0_ADR_I,
  input  logic [7:0]  M0_DAT_I,
  output logic [7:0]  M0_DAT_O,
  output logic        M0_ACK_O,
  output logic        M0_STALL_O,
  output logic        M0_ERR_O,
  input  logic        M1_CYC_I,
  input  logic        M1_STB_I,
  input  logic        M1_WE_I,
  input  logic [31:0] M1_ADR_I,
  input  logic [7:0]  M1_DAT_I,
  output logic [7:0]  M1_DAT_O,
  output logic        M1_ACK_O,
  output logic        M1_STALL_O,
  output logic        M1_ERR_O,
  output logic        S_CYC_O,
  output logic        S_STB_O,
  output logic        S_WE_O,
  output logic [31:0] S_ADR_O,
  output logic [7:0]  S_DAT_O,
  input  logic [7:0]  S_DAT_I,
  input  logic        S_ACK_I,
  input  logic        S_STALL_I,
  output logic [1:0]  O_grant
);

  // Handshake: a request is accepted when STB is high and STALL is low; it
  // completes on the cycle ACK (or ERR together with ACK) is high. CYC frames ownership.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        granted;
  logic        own_cyc, own_stb, own_we;
  logic [31:0] own_adr;
  logic [7:0]  own_dat;
  logic        timeout_fire;
  logic        resp_ack;
  logic [7:0]  resp_dat;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = 32'd0;
    own_dat = 8'd0;
    case (state_q)
      GRANT0: begin
        own_cyc = M0_CYC_I;
        own_stb = M0_STB_I;
        own_we  = M0_WE_I;
        own_adr = M0_ADR_I;
        own_dat = M0_DAT_I;
      end
      GRANT1: begin
        own_cyc = M1_CYC_I;
        own_stb = M1_STB_I;
        own_we  = M1_WE_I;
        own_adr = M1_ADR_I;
        own_dat = M1_DAT_I;
      end
      default: ;
    endcase
  end

  assign granted      = (state_q != IDLE);
  assign timeout_fire = granted && own_stb && !S_ACK_I && (cnt_q == TIMEOUT - 8'd1);
  assign resp_ack     = S_ACK_I || timeout_fire;
  assign resp_dat     = timeout_fire ? 8'hFF : S_DAT_I;

  always_comb begin
    if (!granted || S_ACK_I || !own_stb || timeout_fire) cnt_d = 8'd0;
    else                                                   cnt_d = cnt_q + 8'd1;
  end

  // Tie in IDLE goes to the master not granted last; release always passes through IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (M0_CYC_I && M1_CYC_I) begin
          state_d = last_q ? GRANT0 : GRANT1;
          last_d  = ~last_q;
        end else if (M0_CYC_I) begin
          state_d = GRANT0;
          last_d  = 1'b0;
        end else if (M1_CYC_I) begin
          state_d = GRANT1;
          last_d  = 1'b1;
        end
      end
      GRANT0:  if (!M0_CYC_I) state_d = IDLE;
      GRANT1:  if (!M1_CYC_I) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    S_CYC_O    = 1'b0;
    S_STB_O    = 1'b0;
    S_WE_O     = 1'b0;
    S_ADR_O    = 32'd0;
    S_DAT_O    = 8'd0;
    M0_DAT_O   = 8'd0;
    M0_ACK_O   = 1'b0;
    M0_ERR_O   = 1'b0;
    M0_STALL_O = M0_CYC_I;
    M1_DAT_O   = 8'd0;
    M1_ACK_O   = 1'b0;
    M1_ERR_O   = 1'b0;
    M1_STALL_O = M1_CYC_I;
    if (granted) begin
      S_CYC_O = own_cyc;
      S_STB_O = own_stb && !timeout_fire;
      S_WE_O  = own_we;
      S_ADR_O = own_adr;
      S_DAT_O = own_dat;
    end
    case (state_q)
      GRANT0: begin
        M0_DAT_O   = resp_dat;
        M0_ACK_O   = resp_ack;
        M0_ERR_O   = timeout_fire;
        M0_STALL_O = S_STALL_I;
        M1_STALL_O = 1'b1;
      end
      GRANT1: begin
        M1_DAT_O   = resp_dat;
        M1_ACK_O   = resp_ack;
        M1_ERR_O   = timeout_fire;
        M1_STALL_O = S_STALL_I;
        M0_STALL_O = 1'b1;
      end
      default: ;
    endcase
  end

  assign O_grant = {state_q == GRANT1, state_q == GRANT0};

endmodule
